// File: rtl/rs_dsp_dotprod_seq.sv
// rs_dsp_dotprod_seq
// Operand sequencer for a MULTIPLY_ACCUMULATE DSP38 wrapper with registered output.
// Streams (a, b) pairs into the DSP, counts vector elements, waits out the DSP
// latency, then captures the accumulator output into a result register.
//
// Optional feature macro: RS_DSP_SEQ_TLAST_EN (adds in_last to end a vector early).
//
// Ports:
//   clk, lreset            clock (rising edge), asynchronous active-high reset
//   in_valid/in_ready      operand pair handshake
//   in_a[19:0], in_b[17:0] multiplicand / multiplier
//   in_last                (RS_DSP_SEQ_TLAST_EN only) last element of vector
//   dsp_a, dsp_b           registered operands to the DSP
//   dsp_load_acc           registered; 0 loads the product, 1 accumulates
//   dsp_feedback           constant 3'b000
//   dsp_unsigned_a/b       constant UNSIGNED_OPS
//   dsp_z[37:0]            DSP accumulator output
//   res_valid/res_ready    result handshake
//   res_data[37:0]         registered dot-product result
module rs_dsp_dotprod_seq #(
    parameter int unsigned VEC_LEN      = 16,
    parameter int unsigned PIPE_LAT     = 1,
    parameter int unsigned UNSIGNED_OPS = 0
) (
    input  logic        clk,
    input  logic        lreset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [19:0] in_a,
    input  logic [17:0] in_b,
`ifdef RS_DSP_SEQ_TLAST_EN
    input  logic        in_last,
`endif
    output logic [19:0] dsp_a,
    output logic [17:0] dsp_b,
    output logic        dsp_load_acc,
    output logic [2:0]  dsp_feedback,
    output logic        dsp_unsigned_a,
    output logic        dsp_unsigned_b,
    input  logic [37:0] dsp_z,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [37:0] res_data
);

    typedef enum logic [1:0] {StIdle, StAccum, StDrain, StHold} state_e;

    // Count holds up to 256 elements; drain counter up to PIPE_LAT = 4.
    localparam logic [8:0] LastIdx = 9'(VEC_LEN - 1);
    localparam logic [2:0] DrainEnd = 3'(PIPE_LAT);

    state_e      state_q, state_d;
    logic [8:0]  elem_cnt_q, elem_cnt_d;
    logic [2:0]  drain_cnt_q, drain_cnt_d;
    logic [19:0] dsp_a_q, dsp_a_d;
    logic [17:0] dsp_b_q, dsp_b_d;
    logic        load_acc_q, load_acc_d;
    logic        res_valid_q, res_valid_d;
    logic [37:0] res_data_q, res_data_d;

    logic acc;
    logic last_elem;

    assign in_ready = (state_q == StIdle) || (state_q == StAccum);
    assign acc      = in_valid & in_ready;

    // elem_cnt_q is the index of the element being accepted (0 in IDLE).
`ifdef RS_DSP_SEQ_TLAST_EN
    assign last_elem = (elem_cnt_q == LastIdx) || in_last;
`else
    assign last_elem = (elem_cnt_q == LastIdx);
`endif

    always_comb begin
        state_d     = state_q;
        elem_cnt_d  = elem_cnt_q;
        drain_cnt_d = drain_cnt_q;
        res_valid_d = res_valid_q;
        res_data_d  = res_data_q;
        // Zero operands on idle cycles so the DSP adds 0 and holds its sum.
        dsp_a_d     = acc ? in_a : 20'd0;
        dsp_b_d     = acc ? in_b : 18'd0;
        load_acc_d  = 1'b1;

        unique case (state_q)
            StIdle: begin
                if (acc) begin
                    elem_cnt_d = 9'd1;
                    load_acc_d = 1'b0;
                    if (last_elem) begin
                        state_d     = StDrain;
                        drain_cnt_d = 3'd0;
                    end else begin
                        state_d = StAccum;
                    end
                end
            end
            StAccum: begin
                if (acc) begin
                    elem_cnt_d = elem_cnt_q + 9'd1;
                    if (last_elem) begin
                        state_d     = StDrain;
                        drain_cnt_d = 3'd0;
                    end
                end
            end
            StDrain: begin
                if (drain_cnt_q == DrainEnd) begin
                    res_data_d  = dsp_z;
                    res_valid_d = 1'b1;
                    state_d     = StHold;
                end else begin
                    drain_cnt_d = drain_cnt_q + 3'd1;
                end
            end
            StHold: begin
                if (res_valid_q && res_ready) begin
                    res_valid_d = 1'b0;
                    elem_cnt_d  = 9'd0;
                    state_d     = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge lreset) begin
        if (lreset) begin
            state_q     <= StIdle;
            elem_cnt_q  <= 9'd0;
            drain_cnt_q <= 3'd0;
            dsp_a_q     <= 20'd0;
            dsp_b_q     <= 18'd0;
            load_acc_q  <= 1'b0;
            res_valid_q <= 1'b0;
            res_data_q  <= 38'd0;
        end else begin
            state_q     <= state_d;
            elem_cnt_q  <= elem_cnt_d;
            drain_cnt_q <= drain_cnt_d;
            dsp_a_q     <= dsp_a_d;
            dsp_b_q     <= dsp_b_d;
            load_acc_q  <= load_acc_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
        end
    end

    assign dsp_a          = dsp_a_q;
    assign dsp_b          = dsp_b_q;
    assign dsp_load_acc   = load_acc_q;
    assign dsp_feedback   = 3'b000;
    assign dsp_unsigned_a = (UNSIGNED_OPS != 0);
    assign dsp_unsigned_b = (UNSIGNED_OPS != 0);
    assign res_valid      = res_valid_q;
    assign res_data       = res_data_q;

endmodule

// File: doc/rs_dsp_dotprod_seq.md
Name: rs_dsp_dotprod_seq

Overview:
- Operand sequencer that sits directly upstream of a MULTIPLY_ACCUMULATE DSP38 wrapper with registered output.
- Accepts a valid/ready stream of (a, b) operand pairs and drives the DSP's a/b/load_acc/feedback/sign inputs.
- Counts the elements of each dot-product vector and waits out the DSP output latency.
- Reads back the DSP's z, holds it in a result register and presents it on a valid/ready result port.

Parameters:
- VEC_LEN, 16: elements per dot product; legal range 1..256.
- PIPE_LAT, 1: cycles from a DSP operand register update to z reflecting it; 1 for an output-registered DSP; legal range 1..4.
- UNSIGNED_OPS, 0: 1 drives dsp_unsigned_a/b high; 0 selects signed operands.

Ports:
- clk  in  1  single clock, rising edge.
- lreset  in  1  asynchronous, active-high reset.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  sequencer can accept a pair.
- in_a  in  20  multiplicand.
- in_b  in  18  multiplier.
- dsp_a  out  20  to DSP a; registered.
- dsp_b  out  18  to DSP b; registered.
- dsp_load_acc  out  1  to DSP load_acc; registered.
- dsp_feedback  out  3  to DSP feedback; constant 3'b000.
- dsp_unsigned_a  out  1  constant UNSIGNED_OPS.
- dsp_unsigned_b  out  1  constant UNSIGNED_OPS.
- dsp_z  in  38  DSP accumulator output.
- res_valid  out  1  result available.
- res_ready  in  1  consumer accepts result.
- res_data  out  38  registered dot-product result.

Behaviour:
- Reset values (lreset high, asynchronous): state=IDLE, elem count=0, drain count=0, dsp_a=0, dsp_b=0, dsp_load_acc=0, res_valid=0, res_data=0.
- Accept condition: acc = in_valid & in_ready.
- in_ready = 1 in IDLE and ACCUM; 0 in DRAIN and HOLD. in_ready is a combinational function of state.
- Every cycle in every state:
  - dsp_a <= acc ? in_a : 0; dsp_b <= acc ? in_b : 0.
  - Zeroing on non-accept cycles makes the product 0, so the DSP accumulator holds its value across bubbles.
- dsp_load_acc:
  - <= 0 when accepting element 0 of a vector; the accumulator loads the product only.
  - <= 1 on every other cycle, which adds (accumulates).
- FSM:
  - IDLE: acc -> count=1, load_acc=0. Go to DRAIN if VEC_LEN==1, else ACCUM.
  - ACCUM: acc -> count+1, load_acc=1. Go to DRAIN when the accepted element is index VEC_LEN-1. No acc -> stay; the bubble holds the sum.
  - DRAIN: drain count runs 0..PIPE_LAT. When it reaches PIPE_LAT: res_data <= dsp_z, res_valid <= 1, go to HOLD.
  - HOLD: on res_valid & res_ready: res_valid <= 0, count <= 0, go to IDLE.
- Latency: last element accepted at edge E -> res_valid high after edge E+PIPE_LAT+1. Total PIPE_LAT+1 cycles.
- Throughput: one vector per VEC_LEN + PIPE_LAT + 2 cycles minimum, with no back-pressure.
- Width rule: res_data is dsp_z unmodified. Overflow and wrap of the 38-bit accumulator are the DSP's behaviour; the sequencer performs no saturation.
- res_data is stable while res_valid=1. res_ready while res_valid=0 is ignored.
- Reset asserted mid-vector or mid-HOLD: the partial sum is abandoned and all state returns to reset values. The next vector starts with load_acc=0, so stale DSP contents are discarded.

Optional Feature:
- Macro: RS_DSP_SEQ_TLAST_EN.
- Defined:
  - Adds input port in_last (1 bit).
  - An accepted pair with in_last=1 ends the vector (go to DRAIN) at any count below VEC_LEN.
  - The VEC_LEN count still forces termination at VEC_LEN elements even if in_last is 0.
- Undefined: no in_last port; vectors are exactly VEC_LEN elements.

Test Plan:
- VEC_LEN=4, signed, in_a=1,2,3,4, in_b=5,6,7,8 back-to-back -> res_data=70, res_valid rises 2 cycles after the 4th accept; dsp_load_acc sequence 0,1,1,1.
- Same vectors with in_valid low for 3 cycles between elements 2 and 3 -> dsp_a/dsp_b=0 during the gaps, res_data=70.
- Signed in_a=-3 (20'hFFFFD), in_b=100, VEC_LEN=1 -> res_data=38'h3FFFFFFED4 (-300); the result must not include any prior sum.
- res_ready held low 10 cycles in HOLD -> res_valid and res_data stable, in_ready=0; a 2nd vector of 2*2 x4 (VEC_LEN=4) after release -> 16.
- lreset pulsed after 2 of 4 elements (1*5, 2*6) -> outputs at reset values immediately; a new vector 1,1,1,1 x 1,1,1,1 -> res_data=4.
- RS_DSP_SEQ_TLAST_EN defined, VEC_LEN=8, elements 10*10, 20*20 with in_last on the 2nd -> res_data=500; a 9-pair stream without in_last -> terminates after 8 pairs.
